// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: VGA raster master / timing generator.
// Divides clk into a pixel tick, scans the full H_TOTAL x V_TOTAL raster,
// drives (o_x, o_y) to the pixel source and registers the returned colour
// together with hsync/vsync/de one pixel tick later, so all video outputs
// stay mutually aligned.
module vga_scan_ctrl #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] o_x,
  output logic [15:0] o_y,
  input  logic [7:0]  i_red,
  input  logic [7:0]  i_green,
  input  logic [7:0]  i_blue,
  output logic [3:0]  o_vga_r,
  output logic [3:0]  o_vga_g,
  output logic [3:0]  o_vga_b,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de,
  output logic        o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_ACT    = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT    = 16'(V_ACTIVE);
  localparam logic [15:0] HS_BEG   = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_BEG   = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        SYNC_ON  = (SYNC_POL != 0);
  localparam logic        SYNC_OFF = (SYNC_POL == 0);

  logic [3:0]  div_q, div_d;
  logic [15:0] h_cnt_q, h_cnt_d;
  logic [15:0] v_cnt_q, v_cnt_d;
  logic [3:0]  r_q, r_d, g_q, g_d, b_q, b_d;
  logic        de_q, de_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        fs_q, fs_d;

  logic tick;
  logic h_wrap;
  logic v_last;
  logic de_cur;
  logic hs_cur;
  logic vs_cur;

  // Only the top nibble of each colour reaches the 4-bit DAC.
  logic unused_colour_lsbs;
  assign unused_colour_lsbs = ^{i_red[3:0], i_green[3:0], i_blue[3:0]};

  // Pixel-tick divider: free-running 0..CLK_DIV-1, tick on the last count.
  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? 4'd0 : div_q + 4'd1;
  end

  // Raster counters: h advances every tick, v advances on each h wrap.
  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    v_last  = (v_cnt_q == V_LAST);
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (tick) begin
      h_cnt_d = h_wrap ? 16'd0 : h_cnt_q + 16'd1;
      if (h_wrap) begin
        v_cnt_d = v_last ? 16'd0 : v_cnt_q + 16'd1;
      end
    end
  end

  // Output stage: decode the pixel being presented now and capture it with
  // the source colour on the tick, so every video output lags by one pixel.
  always_comb begin
    de_cur = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hs_cur = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    vs_cur = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
    r_d    = r_q;
    g_d    = g_q;
    b_d    = b_q;
    de_d   = de_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    if (tick) begin
      de_d = de_cur;
      r_d  = de_cur ? i_red[7:4]   : 4'h0;
      g_d  = de_cur ? i_green[7:4] : 4'h0;
      b_d  = de_cur ? i_blue[7:4]  : 4'h0;
      hs_d = hs_cur ? SYNC_ON : SYNC_OFF;
      vs_d = vs_cur ? SYNC_ON : SYNC_OFF;
    end
    // Pulses only on a real wrap, so the (0,0) left by reset never fires it.
    fs_d = tick && h_wrap && v_last;
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= 4'd0;
      h_cnt_q <= 16'd0;
      v_cnt_q <= 16'd0;
      r_q     <= 4'h0;
      g_q     <= 4'h0;
      b_q     <= 4'h0;
      de_q    <= 1'b0;
      hs_q    <= SYNC_OFF;
      vs_q    <= SYNC_OFF;
      fs_q    <= 1'b0;
    end else begin
      div_q   <= div_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs_d;
    end
  end

  assign o_x           = h_cnt_q;
  assign o_y           = v_cnt_q;
  assign o_vga_r       = r_q;
  assign o_vga_g       = g_q;
  assign o_vga_b       = b_q;
  assign o_de          = de_q;
  assign o_hs          = hs_q;
  assign o_vs          = vs_q;
  assign o_frame_start = fs_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Testbench for vga_scan_ctrl using a shrunken raster so whole frames fit in
// a short run: 16+4+6+6 = 32 pixels per line (hsync on h 20..25) and
// 12+2+2+3 = 19 lines per frame (vsync on v 14..15), CLK_DIV = 4.
// After t ticks o_x/o_y show raster position t, while the video outputs
// show pixel t-1.
module tb_vga_scan_ctrl;

  localparam int CLK_DIV = 4;
  localparam int FRAME_CLKS = 32 * 19 * CLK_DIV;   // 2432

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] o_x, o_y;
  logic [7:0]  red_c, green_c, blue_c;
  logic        echo;
  logic [7:0]  i_red, i_green, i_blue;
  logic [3:0]  o_vga_r, o_vga_g, o_vga_b;
  logic        o_hs, o_vs, o_de, o_frame_start;

  int n_tests = 0;
  int n_fail  = 0;
  int cur     = 0;   // posedges since the last reset release

  // Echo mode returns the coordinates as colour to expose alignment errors.
  assign i_red   = echo ? {o_x[3:0], 4'h0} : red_c;
  assign i_green = echo ? {o_y[3:0], 4'h0} : green_c;
  assign i_blue  = blue_c;

  vga_scan_ctrl #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .o_x(o_x), .o_y(o_y),
    .i_red(i_red), .i_green(i_green), .i_blue(i_blue),
    .o_vga_r(o_vga_r), .o_vga_g(o_vga_g), .o_vga_b(o_vga_b),
    .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de), .o_frame_start(o_frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          t;
    logic [15:0] x, y;
    logic        de, hs, vs;
    logic [3:0]  r, g, b;
  } vec_t;

  vec_t vt[19];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Advance to just after posedge number 'target', then sample at negedge.
  task automatic step_to(input int target);
    while (cur < target) begin
      @(posedge clk);
      cur++;
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, {o_x, o_y, o_de, o_hs, o_vs, o_vga_r, o_vga_g, o_vga_b, o_frame_start},
        {16'd0, 16'd0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          found, n, de_n, hs_n, vs_n, hs_low;
    logic [46:0] act, exp;

    // t, x, y, de, hs, vs, r, g, b  (colour constant A5/3C/FF)
    vt[0]  = '{1,   16'd1,  16'd0,  1'b1, 1'b1, 1'b1, 4'hA, 4'h3, 4'hF};
    vt[1]  = '{16,  16'd16, 16'd0,  1'b1, 1'b1, 1'b1, 4'hA, 4'h3, 4'hF};
    vt[2]  = '{17,  16'd17, 16'd0,  1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};
    vt[3]  = '{20,  16'd20, 16'd0,  1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};
    vt[4]  = '{21,  16'd21, 16'd0,  1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0};
    vt[5]  = '{26,  16'd26, 16'd0,  1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0};
    vt[6]  = '{27,  16'd27, 16'd0,  1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};
    vt[7]  = '{32,  16'd0,  16'd1,  1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};
    vt[8]  = '{33,  16'd1,  16'd1,  1'b1, 1'b1, 1'b1, 4'hA, 4'h3, 4'hF};
    vt[9]  = '{368, 16'd16, 16'd11, 1'b1, 1'b1, 1'b1, 4'hA, 4'h3, 4'hF};
    vt[10] = '{369, 16'd17, 16'd11, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};
    vt[11] = '{385, 16'd1,  16'd12, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};
    vt[12] = '{448, 16'd0,  16'd14, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};
    vt[13] = '{449, 16'd1,  16'd14, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0};
    vt[14] = '{502, 16'd22, 16'd15, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};
    vt[15] = '{512, 16'd0,  16'd16, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0};
    vt[16] = '{513, 16'd1,  16'd16, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};
    vt[17] = '{608, 16'd0,  16'd0,  1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};
    vt[18] = '{609, 16'd1,  16'd0,  1'b1, 1'b1, 1'b1, 4'hA, 4'h3, 4'hF};

    // Reset held for 5 clks with a bright source: outputs must stay blank.
    echo    = 1'b0;
    red_c   = 8'hFF;
    green_c = 8'h3C;
    blue_c  = 8'hFF;
    rst_n   = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset_values");
    red_c = 8'hA5;
    rst_n = 1'b1;
    cur   = 0;

    // First tick lands on edge CLK_DIV; no frame pulse right after release.
    step_to(1);
    chk("post_release_fs_x", {o_frame_start, o_x}, {1'b0, 16'd0});
    step_to(3);
    chk("x_before_first_tick", o_x, 16'd0);
    step_to(4);
    chk("first_tick_x_de", {o_x, o_de, o_vga_r}, {16'd1, 1'b1, 4'hA});

    // Table-driven raster probes.
    for (int i = 0; i < 19; i++) begin
      step_to(CLK_DIV * vt[i].t + 1);
      act = {o_x, o_y, o_de, o_hs, o_vs, o_vga_r, o_vga_g, o_vga_b};
      exp = {vt[i].x, vt[i].y, vt[i].de, vt[i].hs, vt[i].vs, vt[i].r, vt[i].g, vt[i].b};
      chk($sformatf("vec[%0d] t=%0d", i, vt[i].t), {17'd0, act}, {17'd0, exp});
    end

    // Whole-frame measurement between consecutive frame-start pulses.
    found = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (o_frame_start) begin found = 1; break; end
    end
    chk("fs_found", found, 1);
    chk("fs_at_origin", {o_x, o_y}, {16'd0, 16'd0});
    n    = 1;
    de_n = int'(o_de);
    hs_n = int'(!o_hs);
    vs_n = int'(!o_vs);
    @(negedge clk);
    chk("fs_width_one_clk", o_frame_start, 1'b0);
    while (!o_frame_start && n < 5000) begin
      n++;
      de_n += int'(o_de);
      hs_n += int'(!o_hs);
      vs_n += int'(!o_vs);
      @(negedge clk);
    end
    chk("frame_period_clks", n, FRAME_CLKS);
    chk("frame_de_clks", de_n, 16 * 12 * CLK_DIV);
    chk("frame_hs_low_clks", hs_n, 19 * 6 * CLK_DIV);
    chk("frame_vs_low_clks", vs_n, 2 * 32 * CLK_DIV);

    // Mid-frame reset while hsync is asserted.
    echo  = 1'b1;
    found = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (o_x == 16'd22 && o_y == 16'd8) begin found = 1; break; end
    end
    chk("pre_reset_in_hsync", {found[0], o_hs}, {1'b1, 1'b0});
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset_values");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cur   = 0;

    // No sync pulse may appear during the first 20 pixels of the new frame.
    hs_low = 0;
    for (int k = 1; k <= 80; k++) begin
      step_to(k);
      hs_low += int'(!o_hs) + int'(!o_vs);
    end
    chk("no_sync_after_reset", hs_low, 0);

    // Coordinate echo on line 5: red carries x, green carries y.
    step_to(CLK_DIV * 161 + 1);
    chk("echo_px0_line5", {o_de, o_vga_r, o_vga_g, o_vga_b}, {1'b1, 4'h0, 4'h5, 4'hF});
    step_to(CLK_DIV * 174 + 1);
    chk("echo_px13_line5", {o_de, o_vga_r, o_vga_g, o_vga_b}, {1'b1, 4'hD, 4'h5, 4'hF});
    step_to(CLK_DIV * 175 + 1);
    chk("echo_px14_line5", {o_de, o_vga_r, o_vga_g, o_vga_b}, {1'b1, 4'hE, 4'h5, 4'hF});
    step_to(CLK_DIV * 177 + 1);
    chk("echo_px16_blank", {o_de, o_vga_r, o_vga_g, o_vga_b}, {1'b0, 4'h0, 4'h0, 4'h0});

    // First frame pulse after reset comes a full frame after release.
    while (!o_frame_start && cur < 3000) step_to(cur + 1);
    chk("fs_after_reset_edge", cur, FRAME_CLKS);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
